// File: rtl/mem_burst_arbiter.sv
// -----------------------------------------------------------------------------
// mem_burst_arbiter
//
// Shares one DDR3 burst controller port between two burst masters. One
// complete burst (read or write) is owned by one master at a time; ties
// between the masters are broken round-robin. A master that raises both its
// read and write requests gets its write serviced first.
//
// Request, address and length toward the controller are registered at grant
// time. Write data, data-request, read data-valid and finish are steered
// combinationally between the controller and the granted master.
//
// Build option:
//   MEM_ARB_FIXED_PRIO_EN  when defined, master 0 always wins a tie and
//                          master 1 is granted only while master 0 is idle.
//                          When undefined, ties alternate round-robin.
//
// Parameters:
//   DATA_WIDTH  burst data width
//   ADDR_WIDTH  burst address width
//
// Ports:
//   phy_clk                 clock, everything is synchronous to it
//   rst_n                   asynchronous active-low reset
//   s_rd_burst_req/_len/_addr      per-master read request, length, address
//   s_wr_burst_req/_len/_addr      per-master write request, length, address
//   s_wr_burst_data         per-master write data (packed, master i in slice i)
//   s_wr_burst_data_req     per-master write data request return
//   s_rd_burst_data_valid   per-master read data valid return
//   s_rd_burst_finish       per-master read finish return
//   s_wr_burst_finish       per-master write finish return
//   s_rd_burst_data         read data, broadcast to both masters
//   m_rd_burst_req/_len/_addr      read request, length, address to controller
//   m_wr_burst_req/_len/_addr      write request, length, address to controller
//   m_wr_burst_data         write data to controller
//   m_wr_burst_data_req     controller write data request
//   m_rd_burst_data_valid   controller read data valid
//   m_rd_burst_finish       controller read finish
//   m_wr_burst_finish       controller write finish
//   m_rd_burst_data         controller read data
//   grant                   one-hot owner of the current burst, 0 when idle
//   busy                    high while a burst is owned
// -----------------------------------------------------------------------------
module mem_burst_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 24
) (
    input  logic                      phy_clk,
    input  logic                      rst_n,

    input  logic [1:0]                s_rd_burst_req,
    input  logic [1:0]                s_wr_burst_req,
    input  logic [19:0]               s_rd_burst_len,
    input  logic [19:0]               s_wr_burst_len,
    input  logic [2*ADDR_WIDTH-1:0]   s_rd_burst_addr,
    input  logic [2*ADDR_WIDTH-1:0]   s_wr_burst_addr,
    input  logic [2*DATA_WIDTH-1:0]   s_wr_burst_data,
    output logic [1:0]                s_wr_burst_data_req,
    output logic [1:0]                s_rd_burst_data_valid,
    output logic [1:0]                s_rd_burst_finish,
    output logic [1:0]                s_wr_burst_finish,
    output logic [DATA_WIDTH-1:0]     s_rd_burst_data,

    output logic                      m_rd_burst_req,
    output logic                      m_wr_burst_req,
    output logic [9:0]                m_rd_burst_len,
    output logic [9:0]                m_wr_burst_len,
    output logic [ADDR_WIDTH-1:0]     m_rd_burst_addr,
    output logic [ADDR_WIDTH-1:0]     m_wr_burst_addr,
    output logic [DATA_WIDTH-1:0]     m_wr_burst_data,
    input  logic                      m_wr_burst_data_req,
    input  logic                      m_rd_burst_data_valid,
    input  logic                      m_rd_burst_finish,
    input  logic                      m_wr_burst_finish,
    input  logic [DATA_WIDTH-1:0]     m_rd_burst_data,

    output logic [1:0]                grant,
    output logic                      busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2
    } state_t;

    state_t                  state_q;
    logic [1:0]              grant_q;
    logic                    last_q;
    logic                    m_wr_req_q;
    logic                    m_rd_req_q;
    logic [9:0]              m_wr_len_q;
    logic [9:0]              m_rd_len_q;
    logic [ADDR_WIDTH-1:0]   m_wr_addr_q;
    logic [ADDR_WIDTH-1:0]   m_rd_addr_q;

    // Arbitration decision, only consumed while IDLE.
    logic [1:0]              want;
    logic                    pick_d;
    logic                    pick_wr_d;
    logic [9:0]              wr_len_d;
    logic [9:0]              rd_len_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_d;
    logic [ADDR_WIDTH-1:0]   rd_addr_d;

    always_comb begin
        want = s_wr_burst_req | s_rd_burst_req;
`ifdef MEM_ARB_FIXED_PRIO_EN
        // Master 1 only when master 0 has nothing to do.
        pick_d = ~want[0];
`else
        // On a tie the master that did not own the previous burst wins.
        if (want == 2'b11) begin
            pick_d = ~last_q;
        end else begin
            pick_d = ~want[0];
        end
`endif
        // Write is serviced before read when one master asks for both.
        pick_wr_d = pick_d ? s_wr_burst_req[1] : s_wr_burst_req[0];

        wr_len_d  = pick_d ? s_wr_burst_len[19:10] : s_wr_burst_len[9:0];
        rd_len_d  = pick_d ? s_rd_burst_len[19:10] : s_rd_burst_len[9:0];
        wr_addr_d = pick_d ? s_wr_burst_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : s_wr_burst_addr[ADDR_WIDTH-1:0];
        rd_addr_d = pick_d ? s_rd_burst_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                           : s_rd_burst_addr[ADDR_WIDTH-1:0];
    end

    always_ff @(posedge phy_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= 2'b00;
            last_q      <= 1'b1;
            m_wr_req_q  <= 1'b0;
            m_rd_req_q  <= 1'b0;
            m_wr_len_q  <= '0;
            m_rd_len_q  <= '0;
            m_wr_addr_q <= '0;
            m_rd_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|want) begin
                        grant_q <= pick_d ? 2'b10 : 2'b01;
                        last_q  <= pick_d;
                        if (pick_wr_d) begin
                            state_q     <= WR;
                            m_wr_req_q  <= 1'b1;
                            m_wr_len_q  <= wr_len_d;
                            m_wr_addr_q <= wr_addr_d;
                        end else begin
                            state_q     <= RD;
                            m_rd_req_q  <= 1'b1;
                            m_rd_len_q  <= rd_len_d;
                            m_rd_addr_q <= rd_addr_d;
                        end
                    end
                end
                WR: begin
                    // Controller has accepted the burst once it asks for data.
                    if (m_wr_burst_data_req) begin
                        m_wr_req_q <= 1'b0;
                    end
                    if (m_wr_burst_finish) begin
                        state_q    <= IDLE;
                        grant_q    <= 2'b00;
                        m_wr_req_q <= 1'b0;
                    end
                end
                RD: begin
                    if (m_rd_burst_data_valid) begin
                        m_rd_req_q <= 1'b0;
                    end
                    if (m_rd_burst_finish) begin
                        state_q    <= IDLE;
                        grant_q    <= 2'b00;
                        m_rd_req_q <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    grant_q    <= 2'b00;
                    m_wr_req_q <= 1'b0;
                    m_rd_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Handshake steering. Handshakes of the type not matching the current
    // burst never reach a master.
    always_comb begin
        s_wr_burst_data_req   = 2'b00;
        s_wr_burst_finish     = 2'b00;
        s_rd_burst_data_valid = 2'b00;
        s_rd_burst_finish     = 2'b00;
        m_wr_burst_data       = '0;
        if (state_q == WR) begin
            s_wr_burst_data_req = grant_q & {2{m_wr_burst_data_req}};
            s_wr_burst_finish   = grant_q & {2{m_wr_burst_finish}};
            m_wr_burst_data     = grant_q[1] ? s_wr_burst_data[2*DATA_WIDTH-1:DATA_WIDTH]
                                             : s_wr_burst_data[DATA_WIDTH-1:0];
        end
        if (state_q == RD) begin
            s_rd_burst_data_valid = grant_q & {2{m_rd_burst_data_valid}};
            s_rd_burst_finish     = grant_q & {2{m_rd_burst_finish}};
        end
    end

    assign s_rd_burst_data = m_rd_burst_data;

    assign m_wr_burst_req  = m_wr_req_q;
    assign m_rd_burst_req  = m_rd_req_q;
    assign m_wr_burst_len  = m_wr_len_q;
    assign m_rd_burst_len  = m_rd_len_q;
    assign m_wr_burst_addr = m_wr_addr_q;
    assign m_rd_burst_addr = m_rd_addr_q;
    assign grant           = grant_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
module tb_mem_burst_arbiter;

    localparam int DW = 64;
    localparam int AW = 24;
`ifdef MEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic            phy_clk;
    logic            rst_n;
    logic [1:0]      s_rd_burst_req, s_wr_burst_req;
    logic [19:0]     s_rd_burst_len, s_wr_burst_len;
    logic [2*AW-1:0] s_rd_burst_addr, s_wr_burst_addr;
    logic [2*DW-1:0] s_wr_burst_data;
    logic [1:0]      s_wr_burst_data_req, s_rd_burst_data_valid;
    logic [1:0]      s_rd_burst_finish, s_wr_burst_finish;
    logic [DW-1:0]   s_rd_burst_data;
    logic            m_rd_burst_req, m_wr_burst_req;
    logic [9:0]      m_rd_burst_len, m_wr_burst_len;
    logic [AW-1:0]   m_rd_burst_addr, m_wr_burst_addr;
    logic [DW-1:0]   m_wr_burst_data;
    logic            m_wr_burst_data_req, m_rd_burst_data_valid;
    logic            m_rd_burst_finish, m_wr_burst_finish;
    logic [DW-1:0]   m_rd_burst_data;
    logic [1:0]      grant;
    logic            busy;

    mem_burst_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .phy_clk(phy_clk), .rst_n(rst_n),
        .s_rd_burst_req(s_rd_burst_req), .s_wr_burst_req(s_wr_burst_req),
        .s_rd_burst_len(s_rd_burst_len), .s_wr_burst_len(s_wr_burst_len),
        .s_rd_burst_addr(s_rd_burst_addr), .s_wr_burst_addr(s_wr_burst_addr),
        .s_wr_burst_data(s_wr_burst_data),
        .s_wr_burst_data_req(s_wr_burst_data_req),
        .s_rd_burst_data_valid(s_rd_burst_data_valid),
        .s_rd_burst_finish(s_rd_burst_finish), .s_wr_burst_finish(s_wr_burst_finish),
        .s_rd_burst_data(s_rd_burst_data),
        .m_rd_burst_req(m_rd_burst_req), .m_wr_burst_req(m_wr_burst_req),
        .m_rd_burst_len(m_rd_burst_len), .m_wr_burst_len(m_wr_burst_len),
        .m_rd_burst_addr(m_rd_burst_addr), .m_wr_burst_addr(m_wr_burst_addr),
        .m_wr_burst_data(m_wr_burst_data),
        .m_wr_burst_data_req(m_wr_burst_data_req),
        .m_rd_burst_data_valid(m_rd_burst_data_valid),
        .m_rd_burst_finish(m_rd_burst_finish), .m_wr_burst_finish(m_wr_burst_finish),
        .m_rd_burst_data(m_rd_burst_data),
        .grant(grant), .busy(busy)
    );

    initial phy_clk = 1'b0;
    always #5 phy_clk = ~phy_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge phy_clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // ---------------- master / controller stimulus state ----------------
    int            pend_wr[2], pend_rd[2];
    bit            wr_fly[2], rd_fly[2];
    logic [9:0]    wlen[2], rlen[2];
    logic [AW-1:0] waddr[2], raddr[2];
    int            wbeat[2];
    int            rcnt;
    int            c_state, c_left, c_cnt;
    bit            c_wr;
    bit            inject_rd1, stray_en;
    int            stray_at;
    logic [1:0]    snap_wdreq, snap_rdv, snap_wfin, snap_rfin;
    logic          snap_mwreq, snap_mrreq;
    logic [9:0]    snap_mwlen, snap_mrlen;

    // ---------------- monitors ----------------
    int         wdreq_cnt[2], rdv_cnt[2], wfin_cnt[2], rfin_cnt[2];
    logic [DW-1:0] last_wdata0;
    int         stray_seen;
    logic       stray_busy;
    bit         gap_arm, gap_wait;
    int         fin_cyc, rise_cyc;
    int         dlog[$], mlog[$];
    logic [1:0] prev_grant;

    // ---------------- reference model ----------------
    bit            e_busy = 1'b0, e_is_wr = 1'b0, e_mwreq = 1'b0, e_mrreq = 1'b0;
    int            e_owner = 0, e_last = 1;
    logic [9:0]    e_wlen = '0, e_rlen = '0;
    logic [AW-1:0] e_waddr = '0, e_raddr = '0;

    task automatic model_step();
        bit w0, w1;
        if (!rst_n) begin
            e_busy = 0; e_is_wr = 0; e_mwreq = 0; e_mrreq = 0;
            e_owner = 0; e_last = 1;
            e_wlen = '0; e_rlen = '0; e_waddr = '0; e_raddr = '0;
        end else if (!e_busy) begin
            w0 = s_wr_burst_req[0] | s_rd_burst_req[0];
            w1 = s_wr_burst_req[1] | s_rd_burst_req[1];
            if (w0 || w1) begin
                if (w0 && w1) e_owner = FIXED ? 0 : 1 - e_last;
                else          e_owner = w0 ? 0 : 1;
                e_last  = e_owner;
                e_busy  = 1;
                e_is_wr = s_wr_burst_req[e_owner];
                if (e_is_wr) begin
                    e_mwreq = 1;
                    e_waddr = s_wr_burst_addr[e_owner*AW +: AW];
                    e_wlen  = s_wr_burst_len[e_owner*10 +: 10];
                end else begin
                    e_mrreq = 1;
                    e_raddr = s_rd_burst_addr[e_owner*AW +: AW];
                    e_rlen  = s_rd_burst_len[e_owner*10 +: 10];
                end
                mlog.push_back(e_owner + (e_is_wr ? 0 : 2));
            end
        end else if (e_is_wr) begin
            if (m_wr_burst_data_req) e_mwreq = 0;
            if (m_wr_burst_finish) begin e_busy = 0; e_mwreq = 0; end
        end else begin
            if (m_rd_burst_data_valid) e_mrreq = 0;
            if (m_rd_burst_finish) begin e_busy = 0; e_mrreq = 0; end
        end
    endtask

    always @(posedge phy_clk or negedge rst_n) model_step();

    // Per-cycle comparison of every output against the model.
    task automatic compare_step();
        logic [1:0] eg, ewdr, ewf, erv, erf;
        logic [DW-1:0] ewd;
        eg = 2'b00; ewdr = 2'b00; ewf = 2'b00; erv = 2'b00; erf = 2'b00; ewd = '0;
        if (e_busy) begin
            eg[e_owner] = 1'b1;
            if (e_is_wr) begin
                ewdr[e_owner] = m_wr_burst_data_req;
                ewf[e_owner]  = m_wr_burst_finish;
                ewd = s_wr_burst_data[e_owner*DW +: DW];
            end else begin
                erv[e_owner] = m_rd_burst_data_valid;
                erf[e_owner] = m_rd_burst_finish;
            end
        end
        chk("grant", grant, eg);
        chk("busy", busy, e_busy);
        chk("m_wr_req", m_wr_burst_req, e_mwreq);
        chk("m_rd_req", m_rd_burst_req, e_mrreq);
        chk("m_wr_addr", m_wr_burst_addr, e_waddr);
        chk("m_wr_len", m_wr_burst_len, e_wlen);
        chk("m_rd_addr", m_rd_burst_addr, e_raddr);
        chk("m_rd_len", m_rd_burst_len, e_rlen);
        chk("m_wr_data", m_wr_burst_data, ewd);
        chk("s_wr_data_req", s_wr_burst_data_req, ewdr);
        chk("s_wr_finish", s_wr_burst_finish, ewf);
        chk("s_rd_valid", s_rd_burst_data_valid, erv);
        chk("s_rd_finish", s_rd_burst_finish, erf);
        chk("s_rd_data", s_rd_burst_data, m_rd_burst_data);
    endtask

    always @(negedge phy_clk) compare_step();

    task automatic monitor_step();
        for (int i = 0; i < 2; i++) begin
            if (s_wr_burst_data_req[i]) wdreq_cnt[i]++;
            if (s_rd_burst_data_valid[i]) rdv_cnt[i]++;
            if (s_wr_burst_finish[i]) wfin_cnt[i]++;
            if (s_rd_burst_finish[i]) rfin_cnt[i]++;
        end
        if (s_wr_burst_data_req[0]) last_wdata0 = m_wr_burst_data;
        if (m_wr_burst_finish && !c_wr) begin stray_seen++; stray_busy = busy; end
        if (gap_arm && m_wr_burst_finish) begin fin_cyc = cyc; gap_arm = 0; gap_wait = 1; end
        if (gap_wait && m_rd_burst_req) begin rise_cyc = cyc; gap_wait = 0; end
        if (grant != 2'b00 && prev_grant == 2'b00)
            dlog.push_back((grant[1] ? 1 : 0) + (m_rd_burst_req ? 2 : 0));
        prev_grant = grant;
        snap_wdreq = s_wr_burst_data_req; snap_rdv = s_rd_burst_data_valid;
        snap_wfin = s_wr_burst_finish;    snap_rfin = s_rd_burst_finish;
        snap_mwreq = m_wr_burst_req;      snap_mrreq = m_rd_burst_req;
        snap_mwlen = m_wr_burst_len;      snap_mrlen = m_rd_burst_len;
    endtask

    always @(negedge phy_clk) monitor_step();

    // Masters and DDR3 controller behaviour, driven just after each edge.
    task automatic drive_step();
        for (int i = 0; i < 2; i++) begin
            if (snap_wdreq[i]) begin wr_fly[i] = 1; wbeat[i]++; end
            if (snap_rdv[i]) rd_fly[i] = 1;
            if (snap_wfin[i]) begin wr_fly[i] = 0; if (pend_wr[i] > 0) pend_wr[i]--; end
            if (snap_rfin[i]) begin rd_fly[i] = 0; if (pend_rd[i] > 0) pend_rd[i]--; end
        end
        m_wr_burst_data_req = 0; m_rd_burst_data_valid = 0;
        m_wr_burst_finish = 0;   m_rd_burst_finish = 0;
        case (c_state)
            0: begin
                if (snap_mwreq) begin c_wr = 1; c_left = int'(snap_mwlen); c_cnt = 0; c_state = 1; end
                else if (snap_mrreq) begin c_wr = 0; c_left = int'(snap_mrlen); c_cnt = 0; c_state = 1; end
            end
            1: c_state = 2;
            2: begin
                if (c_wr) m_wr_burst_data_req = 1;
                else begin
                    m_rd_burst_data_valid = 1;
                    m_rd_burst_data = 64'hBEEF_0000_0000_0000 + 64'(rcnt);
                    rcnt++;
                end
                if (stray_en && !c_wr && c_cnt == stray_at) m_wr_burst_finish = 1;
                c_cnt++;
                c_left--;
                if (c_left <= 0) c_state = 3;
            end
            default: begin
                if (c_wr) m_wr_burst_finish = 1; else m_rd_burst_finish = 1;
                if (inject_rd1) begin pend_rd[1] = 1; inject_rd1 = 0; end
                c_state = 0;
            end
        endcase
        for (int i = 0; i < 2; i++) begin
            s_wr_burst_req[i] = (pend_wr[i] > 0) && !wr_fly[i];
            s_rd_burst_req[i] = (pend_rd[i] > 0) && !rd_fly[i];
        end
        s_wr_burst_data = {64'hD0D1_0000_0000_0000 + 64'(wbeat[1]),
                           64'hD0D0_0000_0000_0000 + 64'(wbeat[0])};
        s_wr_burst_addr = {waddr[1], waddr[0]};
        s_rd_burst_addr = {raddr[1], raddr[0]};
        s_wr_burst_len  = {wlen[1], wlen[0]};
        s_rd_burst_len  = {rlen[1], rlen[0]};
    endtask

    always @(posedge phy_clk) begin
        #1;
        if (rst_n) drive_step();
    end

    task automatic bench_reset();
        for (int i = 0; i < 2; i++) begin
            pend_wr[i] = 0; pend_rd[i] = 0; wr_fly[i] = 0; rd_fly[i] = 0;
            wlen[i] = '0; rlen[i] = '0; waddr[i] = '0; raddr[i] = '0; wbeat[i] = 0;
        end
        rcnt = 0; c_state = 0; c_left = 0; c_cnt = 0; c_wr = 0;
        inject_rd1 = 0; stray_en = 0; stray_at = 0;
        snap_wdreq = '0; snap_rdv = '0; snap_wfin = '0; snap_rfin = '0;
        snap_mwreq = 0; snap_mrreq = 0; snap_mwlen = '0; snap_mrlen = '0;
        s_rd_burst_req = '0; s_wr_burst_req = '0; s_rd_burst_len = '0; s_wr_burst_len = '0;
        s_rd_burst_addr = '0; s_wr_burst_addr = '0; s_wr_burst_data = '0;
        m_wr_burst_data_req = 0; m_rd_burst_data_valid = 0;
        m_rd_burst_finish = 0; m_wr_burst_finish = 0; m_rd_burst_data = '0;
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin
            wdreq_cnt[i] = 0; rdv_cnt[i] = 0; wfin_cnt[i] = 0; rfin_cnt[i] = 0;
        end
        last_wdata0 = '0; stray_seen = 0; stray_busy = 0;
        gap_arm = 0; gap_wait = 0; fin_cyc = 0; rise_cyc = 0;
        dlog.delete(); mlog.delete();
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge phy_clk);
            n++;
        end while (!(pend_wr[0] == 0 && pend_wr[1] == 0 && pend_rd[0] == 0 &&
                     pend_rd[1] == 0 && c_state == 0 && !busy) && n < budget);
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL %s timeout after %0d cycles", nm, n);
        end
    endtask

    task automatic chk_log(input string nm, input int n, input int a0, input int a1,
                           input int a2, input int a3);
        int a[4];
        a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
        chk({nm, "_dut_count"}, dlog.size(), n);
        chk({nm, "_model_count"}, mlog.size(), n);
        for (int k = 0; k < n; k++) begin
            if (k < dlog.size()) chk({nm, "_dut"}, dlog[k], a[k]);
            if (k < mlog.size()) chk({nm, "_model"}, mlog[k], a[k]);
        end
    endtask

    initial begin
        int n;
        bench_reset();
        clear_counts();
        prev_grant = 2'b00;
        rst_n = 0;
        repeat (3) @(negedge phy_clk);
        chk("reset_grant", grant, 2'b00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_m_wr_req", m_wr_burst_req, 1'b0);
        chk("reset_m_wr_addr", m_wr_burst_addr, 24'h0);
        chk("reset_m_rd_len", m_rd_burst_len, 10'd0);
        #1 rst_n = 1;

        // Single write from master 0.
        @(negedge phy_clk);
        clear_counts();
        waddr[0] = 24'h000100; wlen[0] = 10'd255; pend_wr[0] = 1;
        n = 0;
        do begin @(negedge phy_clk); n++; end while (!s_wr_burst_req[0] && n < 10);
        chk("t1_req_seen", s_wr_burst_req[0], 1'b1);
        chk("t1_m_req_not_yet", m_wr_burst_req, 1'b0);
        @(negedge phy_clk);
        chk("t1_m_req_rise", m_wr_burst_req, 1'b1);
        chk("t1_addr", m_wr_burst_addr, 24'h000100);
        chk("t1_len", m_wr_burst_len, 10'd255);
        chk("t1_grant", grant, 2'b01);
        wait_done("t1", 1000);
        chk("t1_dreq0", wdreq_cnt[0], 255);
        chk("t1_dreq1", wdreq_cnt[1], 0);
        chk("t1_last_wdata", last_wdata0, 64'hD0D0_0000_0000_00FE);
        chk("t1_fin0", wfin_cnt[0], 1);
        chk("t1_fin1", wfin_cnt[1], 0);
        chk_log("t1_log", 1, 0, 0, 0, 0);

        // Master 1 asks for write and read together.
        clear_counts();
        waddr[1] = 24'h000200; wlen[1] = 10'd8;
        raddr[1] = 24'h000300; rlen[1] = 10'd255;
        pend_wr[1] = 1; pend_rd[1] = 1;
        wait_done("t3", 2000);
        chk_log("t3_log", 2, 1, 3, 0, 0);
        chk("t3_rdv1", rdv_cnt[1], 255);
        chk("t3_rdv0", rdv_cnt[0], 0);
        chk("t3_rfin1", rfin_cnt[1], 1);

        // Finish coincides with the other master's new request.
        clear_counts();
        wlen[0] = 10'd6; raddr[1] = 24'h0003F0; rlen[1] = 10'd9;
        inject_rd1 = 1; gap_arm = 1; pend_wr[0] = 1;
        wait_done("t4", 500);
        chk("t4_gap", rise_cyc - fin_cyc, 2);
        chk_log("t4_log", 2, 0, 3, 0, 0);

        // Stray write finish during a read.
        clear_counts();
        raddr[0] = 24'h000040; rlen[0] = 10'd20;
        stray_en = 1; stray_at = 5; pend_rd[0] = 1;
        wait_done("t6", 500);
        stray_en = 0;
        chk("t6_stray_seen", stray_seen, 1);
        chk("t6_busy_at_stray", stray_busy, 1'b1);
        chk("t6_wfin", wfin_cnt[0] + wfin_cnt[1], 0);
        chk("t6_rdv0", rdv_cnt[0], 20);
        chk("t6_rfin0", rfin_cnt[0], 1);

        // Reset mid-read after about 100 beats.
        clear_counts();
        raddr[0] = 24'h00ABCD; rlen[0] = 10'd200; pend_rd[0] = 1;
        n = 0;
        do begin @(negedge phy_clk); n++; end while (rdv_cnt[0] < 100 && n < 500);
        chk("t5_reached_100", rdv_cnt[0] >= 100, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("t5_grant", grant, 2'b00);
        chk("t5_busy", busy, 1'b0);
        chk("t5_m_rd_req", m_rd_burst_req, 1'b0);
        chk("t5_m_rd_addr", m_rd_burst_addr, 24'h0);
        chk("t5_m_rd_len", m_rd_burst_len, 10'd0);
        chk("t5_m_wr_addr", m_wr_burst_addr, 24'h0);
        chk("t5_m_wr_len", m_wr_burst_len, 10'd0);
        chk("t5_s_rd_valid", s_rd_burst_data_valid, 2'b00);
        chk("t5_s_wr_dreq", s_wr_burst_data_req, 2'b00);
        bench_reset();
        repeat (2) @(negedge phy_clk);
        #1 rst_n = 1;
        @(negedge phy_clk);

        // Both masters write twice; first tie after reset goes to master 0.
        clear_counts();
        waddr[0] = 24'h000500; waddr[1] = 24'h000600;
        wlen[0] = 10'd4; wlen[1] = 10'd4;
        pend_wr[0] = 2; pend_wr[1] = 2;
        wait_done("t2", 500);
        if (FIXED) chk_log("t2_log", 4, 0, 0, 1, 1);
        else       chk_log("t2_log", 4, 0, 1, 0, 1);
        chk("t2_fin0", wfin_cnt[0], 2);
        chk("t2_fin1", wfin_cnt[1], 2);

        repeat (3) @(negedge phy_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_arbiter.md
# mem_burst_arbiter

Two-port arbiter that shares the single DDR3 burst interface (req/len/addr/data/finish handshake on `phy_clk`) between two burst masters, e.g. a test/pattern engine and a video frame writer. It sits between the masters and the DDR3 burst controller and grants one complete burst (read or write) at a time with round-robin fairness. Address, length and request are registered toward the controller; data, data-request, data-valid and finish are steered combinationally to the granted master.

## Interface
- `DATA_WIDTH`, 64, burst data width.
- `ADDR_WIDTH`, 24, burst address width.
- `phy_clk`  in  1  the only clock; everything is synchronous to it.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_rd_burst_req` / `s_wr_burst_req`  in  2  per-master requests; bit *i* is master *i*.
- `s_rd_burst_len` / `s_wr_burst_len`  in  2×10  packed; master *i* at `[10i+9:10i]`.
- `s_rd_burst_addr` / `s_wr_burst_addr`  in  2×ADDR_WIDTH  packed, same layout.
- `s_wr_burst_data`  in  2×DATA_WIDTH  packed write data.
- `s_wr_burst_data_req`, `s_rd_burst_data_valid`, `s_rd_burst_finish`, `s_wr_burst_finish`  out  2  per-master handshake returns.
- `s_rd_burst_data`  out  DATA_WIDTH  read data broadcast to both masters.
- `m_rd_burst_req`, `m_wr_burst_req`  out  1  requests to the DDR3 controller.
- `m_rd_burst_len`, `m_wr_burst_len`  out  10  burst lengths.
- `m_rd_burst_addr`, `m_wr_burst_addr`  out  ADDR_WIDTH  burst addresses.
- `m_wr_burst_data`  out  DATA_WIDTH  write data to the controller.
- `m_wr_burst_data_req`, `m_rd_burst_data_valid`, `m_rd_burst_finish`, `m_wr_burst_finish`  in  1  controller handshake.
- `m_rd_burst_data`  in  DATA_WIDTH  read data from the controller.
- `grant`  out  2  one-hot owner of the current burst; 0 when idle.
- `busy`  out  1  high while the arbiter is not in IDLE.

## Operation
- FSM states: IDLE, WR, RD.
- In IDLE, master *i* is requesting if `s_wr_burst_req[i] | s_rd_burst_req[i]`.
- If both masters request, the master not granted last wins. The `last` register resets to 1, so master 0 wins the first tie.
- If the chosen master asserts both rd and wr requests, the write is serviced first.
- On grant (IDLE → WR or RD):
  - register `grant`, set `last` to the granted master;
  - latch that master's addr and len onto the `m_*` addr/len outputs;
  - set `m_wr_burst_req` or `m_rd_burst_req` to 1.
- `m_*_burst_req` stays high until the first `m_wr_burst_data_req` (WR) or `m_rd_burst_data_valid` (RD), then clears. Addr and len hold until the next grant.
- Routing while in WR:
  - `s_wr_burst_data_req[g] = m_wr_burst_data_req`;
  - `m_wr_burst_data` = master g's slice;
  - `s_wr_burst_finish[g] = m_wr_burst_finish`.
- Routing while in RD:
  - `s_rd_burst_data_valid[g] = m_rd_burst_data_valid`;
  - `s_rd_burst_finish[g] = m_rd_burst_finish`.
- Non-granted handshake outputs are 0. `m_wr_burst_data` is 0 outside WR.
- WR → IDLE on `m_wr_burst_finish`; RD → IDLE on `m_rd_burst_finish`. `grant` clears in the same transition.
- Finish or data handshakes of the wrong type for the current state are ignored.
- Masters must drop their request by their first data-req/valid. A request still high in IDLE is treated as a new burst.
- Reset (async, any state, including mid-burst):
  - state = IDLE, `grant` = 0, `busy` = 0, `last` = 1;
  - all `m_*` req/len/addr = 0; all handshake outputs = 0.

## Timing
- Grant latency: request sampled in IDLE at edge N → `m_*_burst_req`, addr, len and `grant` valid after edge N.
- Data, data_req, data_valid and finish paths: 0-cycle combinational pass-through.
- Finish at edge M → IDLE after M. The earliest next `m_*_burst_req` is after edge M+1, so bursts are separated by 1 idle cycle.
- `m_*_burst_req` drops on the edge that samples the first data_req/data_valid.

## Configuration
- `MEM_ARB_FIXED_PRIO_EN` defined: master 0 always wins ties; `last` is still recorded but unused.
  - Master 1 is granted only when master 0 is not requesting in IDLE.
- Undefined (default): round-robin as described under Operation.
- Write-before-read within one master is unchanged in both modes.

## Test plan
- Reset, then master 0 issues a write with addr 0x000100 and len 255:
  - `m_wr_burst_req` rises 1 cycle later with addr 0x000100 and len 255;
  - after 255 data_req pulses, `s_wr_burst_data` slice 0 appears on `m_wr_burst_data`;
  - finish reaches `s_wr_burst_finish[0]` only.
- Both masters request a write in the same cycle, with master 1 re-requesting after each finish:
  - grants alternate 0, 1, 0, 1;
  - under `MEM_ARB_FIXED_PRIO_EN`, with master 0 re-requesting continuously, grants are 0, 0, 0.
- Master 1 asserts rd and wr together:
  - write granted first, then read;
  - `s_rd_burst_data_valid[1]` pulses 255 times and `s_rd_burst_data_valid[0]` stays 0.
- Finish coincides with a new request from the other master:
  - 1 idle cycle occurs, then `m_*_burst_req` rises on the second edge after finish.
- `rst_n` asserted mid-read after 100 beats:
  - all outputs 0 immediately (asynchronous);
  - after release, a master 0 request is granted first.
- Stray `m_wr_burst_finish` during RD:
  - state stays RD and `s_wr_burst_finish` stays 0.
